// File: rtl/src_div.sv
// ----------------------------------------------------------------------------
// src_div: sequential unsigned restoring divider, the inverse of the 6x6
// multiplier src. Divides a 12-bit dividend by a 6-bit divisor and produces
// one quotient bit per clock under a START/DONE handshake.
//
// Ports
//   clk    in   1   clock, all state updates on the rising edge
//   rst    in   1   synchronous active-high reset
//   START  in   1   request, sampled only while idle
//   T      in  12   dividend, captured on an accepted START
//   G      in   6   divisor, captured on an accepted START
//   BUSY   out  1   high while a division is running or finishing
//   DONE   out  1   one-cycle pulse, Q/R/DZ valid
//   Q      out 12   quotient (12'hFFF on divide by zero)
//   R      out  6   remainder (< G when DZ=0)
//   DZ     out  1   divide-by-zero flag for the current result
// ----------------------------------------------------------------------------
module src_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        START,
  input  logic [11:0] T,
  input  logic [5:0]  G,
  output logic        BUSY,
  output logic        DONE,
  output logic [11:0] Q,
  output logic [5:0]  R,
  output logic        DZ
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] LAST_ITER = 4'd11;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [6:0]  r_p;     // partial remainder
  logic [11:0] r_dvd;   // dividend shifting out, quotient shifting in
  logic [5:0]  r_dvs;
  logic [11:0] r_q;
  logic [5:0]  r_r;
  logic        r_dz;

  logic [6:0]  w_p_shift;
  logic        w_ge;
  logic [6:0]  w_p_next;
  logic        w_unused_p;

  // P stays below the divisor (< 64) between steps, so its top bit is always
  // zero going into the shift and is dropped here.
  assign w_p_shift  = {r_p[5:0], r_dvd[11]};
  assign w_ge       = (w_p_shift >= {1'b0, r_dvs});
  assign w_p_next   = w_ge ? (w_p_shift - {1'b0, r_dvs}) : w_p_shift;
  assign w_unused_p = r_p[6];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_p     <= 7'd0;
      r_dvd   <= 12'd0;
      r_dvs   <= 6'd0;
      r_q     <= 12'd0;
      r_r     <= 6'd0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            if (G == 6'd0) begin
              // Divide by zero resolves immediately without iterating.
              r_q     <= 12'hFFF;
              r_r     <= 6'd0;
              r_dz    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_dvd   <= T;
              r_dvs   <= G;
              r_p     <= 7'd0;
              r_cnt   <= 4'd0;
              r_dz    <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_dvd <= {r_dvd[10:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_ITER) begin
            r_q     <= {r_dvd[10:0], w_ge};
            r_r     <= w_p_next[5:0];
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from state registers; no input reaches an output.
  assign BUSY = (r_state == S_RUN) || (r_state == S_FIN);
  assign DONE = (r_state == S_FIN);
  assign Q    = r_q;
  assign R    = r_r;
  assign DZ   = r_dz;

endmodule

// File: tb/tb_src_div.sv
module tb_src_div;

  logic        clk;
  logic        rst;
  logic        START;
  logic [11:0] T;
  logic [5:0]  G;
  logic        BUSY;
  logic        DONE;
  logic [11:0] Q;
  logic [5:0]  R;
  logic        DZ;

  int n_vec;
  int n_err;

  src_div dut (
    .clk   (clk),
    .rst   (rst),
    .START (START),
    .T     (T),
    .G     (G),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q     (Q),
    .R     (R),
    .DZ    (DZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse START for one cycle; lat = edges from acceptance to DONE (-1 on
  // timeout), busy_n = samples with BUSY high from the accepting edge on.
  task automatic do_div(input logic [11:0] t, input logic [5:0] g,
                        output int lat, output int busy_n);
    T = t;
    G = g;
    START = 1'b1;
    @(posedge clk);
    #1;
    START = 1'b0;
    T = 12'($urandom);
    G = 6'($urandom);
    lat = -1;
    busy_n = BUSY ? 1 : 0;
    if (DONE) begin
      lat = 0;
    end else begin
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        if (BUSY) busy_n++;
        if (DONE) begin
          lat = k;
          break;
        end
      end
    end
  endtask

  task automatic after_done(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, {31'd0, DONE}, 32'd0);
    chk({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic div_check(input string tag, input logic [11:0] t, input logic [5:0] g,
                           input logic [11:0] eq, input logic [5:0] er, input logic edz,
                           input int elat);
    int lat;
    int bn;
    do_div(t, g, lat, bn);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, {20'd0, Q}, {20'd0, eq});
    chk({tag, "_r"}, {26'd0, R}, {26'd0, er});
    chk({tag, "_dz"}, {31'd0, DZ}, {31'd0, edz});
    after_done(tag);
  endtask

  initial begin
    int lat;
    int bn;
    int pulses;
    int seen;
    logic prev_done;
    logic [5:0]  gg;
    logic [11:0] ff;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    START = 1'b0;
    T = 12'd0;
    G = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_q", {20'd0, Q}, 32'd0);
    chk("rst_r", {26'd0, R}, 32'd0);
    chk("rst_dz", {31'd0, DZ}, 32'd0);

    // 3969 = 63*63, with latency and BUSY width.
    do_div(12'd3969, 6'd63, lat, bn);
    chk("sq_lat", lat, 12);
    chk("sq_busy", bn, 13);
    chk("sq_q", {20'd0, Q}, 32'd63);
    chk("sq_r", {26'd0, R}, 32'd0);
    chk("sq_dz", {31'd0, DZ}, 32'd0);
    after_done("sq");

    div_check("d100_7", 12'd100, 6'd7, 12'd14, 6'd2, 1'b0, 12);
    div_check("d4095_1", 12'd4095, 6'd1, 12'd4095, 6'd0, 1'b0, 12);
    div_check("d0_5", 12'd0, 6'd5, 12'd0, 6'd0, 1'b0, 12);

    // Divide by zero: DONE right after the accepting edge, one BUSY cycle.
    do_div(12'd1234, 6'd0, lat, bn);
    chk("dz_lat", lat, 0);
    chk("dz_busy", bn, 1);
    chk("dz_q", {20'd0, Q}, 32'hFFF);
    chk("dz_r", {26'd0, R}, 32'd0);
    chk("dz_flag", {31'd0, DZ}, 32'd1);
    after_done("dz");
    div_check("d10_3", 12'd10, 6'd3, 12'd3, 6'd1, 1'b0, 12);

    // START held high; operands disturbed mid-run, restored before the next
    // acceptance.
    T = 12'd500;
    G = 6'd9;
    START = 1'b1;
    @(posedge clk);
    #1;
    pulses = 0;
    prev_done = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      @(posedge clk);
      #1;
      if (i == 3 || i == 17) begin
        T = 12'd4000;
        G = 6'd0;
      end
      if (i == 8 || i == 21) begin
        T = 12'd500;
        G = 6'd9;
      end
      if (DONE) begin
        pulses++;
        chk("hold_q", {20'd0, Q}, 32'd55);
        chk("hold_r", {26'd0, R}, 32'd5);
        chk("hold_no_double", {31'd0, prev_done}, 32'd0);
      end
      prev_done = DONE;
    end
    START = 1'b0;
    chk("hold_pulses", pulses, 2);
    seen = 0;
    for (int i = 0; i < 20 && BUSY; i++) begin
      @(posedge clk);
      #1;
    end
    chk("hold_drain", {31'd0, BUSY}, 32'd0);

    // Reset sampled at iteration 6 of 2000/40 aborts the run.
    T = 12'd2000;
    G = 6'd40;
    START = 1'b1;
    @(posedge clk);
    #1;
    START = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_q", {20'd0, Q}, 32'd0);
    chk("abort_r", {26'd0, R}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (DONE) seen++;
    end
    chk("abort_no_done", seen, 0);
    div_check("d2000_40", 12'd2000, 6'd40, 12'd50, 6'd0, 1'b0, 12);

    // Products of a random factor pair divide back exactly.
    for (int n = 0; n < 16; n++) begin
      gg = 6'($urandom_range(1, 63));
      ff = 12'($urandom_range(0, 4095 / int'(gg)));
      div_check("prod", 12'(ff * gg), gg, ff, 6'd0, 1'b0, 12);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
